// File: rtl/space_invaders_pkg.sv
// Shared PS/2 keyboard decode types: key code width, prefix bytes and prefix FSM states.
package space_invaders_pkg;

  localparam int KEYCODE_WIDTH = 9;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } pfx_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizes the keyboard lines, shifts in 11-bit frames, flags bad frames.
// Parity is enforced only when PS2_PARITY_CHECK_EN is defined.
module ps2_frame_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

  logic           r_clk_s1, r_clk_s2, r_clk_prev;
  logic           r_dat_s1, r_dat_s2;
  logic [3:0]     r_bitcnt;
  logic [7:0]     r_shift;
  logic           r_par;
  logic [TOW-1:0] r_tocnt;

  logic w_fall, w_stop, w_par_ok, w_frame_ok, w_tout;

  assign w_fall = r_clk_prev & ~r_clk_s2;
  assign w_stop = w_fall & (r_bitcnt == 4'd10);

`ifdef PS2_PARITY_CHECK_EN
  assign w_par_ok = ^{r_shift, r_par};
`else
  logic w_unused_par;
  assign w_unused_par = r_par;
  assign w_par_ok     = 1'b1;
`endif

  assign w_frame_ok = r_dat_s2 & w_par_ok;
  // Timeout only fires on a quiet cycle, so an edge arriving exactly at the limit still counts.
  assign w_tout     = (r_bitcnt != 4'd0) & ~w_fall & (r_tocnt >= TOW'(TIMEOUT_CYCLES));

  assign o_byte       = r_shift;
  assign o_byte_valid = w_stop & w_frame_ok;
  assign o_frame_err  = (w_stop & ~w_frame_ok) | w_tout;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= i_ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= i_ps2_dat;
      r_dat_s2   <= r_dat_s1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_bitcnt <= 4'd0;
      r_shift  <= 8'd0;
      r_par    <= 1'b0;
      r_tocnt  <= '0;
    end else if (w_tout) begin
      r_bitcnt <= 4'd0;
      r_tocnt  <= '0;
    end else if (w_fall) begin
      r_tocnt <= '0;
      if (r_bitcnt == 4'd0) begin
        if (!r_dat_s2) r_bitcnt <= 4'd1;
      end else if (r_bitcnt <= 4'd8) begin
        r_shift  <= {r_dat_s2, r_shift[7:1]};
        r_bitcnt <= r_bitcnt + 4'd1;
      end else if (r_bitcnt == 4'd9) begin
        r_par    <= r_dat_s2;
        r_bitcnt <= 4'd10;
      end else begin
        r_bitcnt <= 4'd0;
      end
    end else if (r_bitcnt != 4'd0) begin
      r_tocnt <= r_tocnt + TOW'(1);
    end else begin
      r_tocnt <= '0;
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 scan-code decoder: tracks E0/F0 prefixes and emits key code with make/brake pulses.
// Optional parity enforcement via PS2_PARITY_CHECK_EN (passed through to ps2_frame_rx).
module ps2_scan_decoder #(
  parameter int KEYCODE_WIDTH  = space_invaders_pkg::KEYCODE_WIDTH,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     PS2_CLK,
  input  logic                     PS2_DAT,
  output logic [KEYCODE_WIDTH-1:0] keyCode,
  output logic                     make,
  output logic                     brake,
  output logic                     frameErr
);

  import space_invaders_pkg::*;

  logic [7:0] w_byte;
  logic       w_byte_valid, w_frame_err;

  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk         (clk),
    .resetN      (resetN),
    .i_ps2_clk   (PS2_CLK),
    .i_ps2_dat   (PS2_DAT),
    .o_byte      (w_byte),
    .o_byte_valid(w_byte_valid),
    .o_frame_err (w_frame_err)
  );

  pfx_state_t r_state, w_nxt;
  logic       w_load, w_make, w_brake, w_ext;
  logic [KEYCODE_WIDTH-1:0] r_keycode;
  logic       r_make, r_brake, r_frame_err;

  assign w_ext = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);

  always_comb begin
    w_nxt   = r_state;
    w_load  = 1'b0;
    w_make  = 1'b0;
    w_brake = 1'b0;
    // Any discarded frame drops a pending prefix so a stray half-sequence cannot tag the next key.
    if (w_frame_err) begin
      w_nxt = ST_IDLE;
    end else if (w_byte_valid) begin
      case (w_byte)
        PFX_EXT: if (r_state == ST_IDLE) w_nxt = ST_EXT;
        PFX_BRK: begin
          if (r_state == ST_IDLE)     w_nxt = ST_BRK;
          else if (r_state == ST_EXT) w_nxt = ST_EXT_BRK;
        end
        PFX_PAUSE: w_nxt = ST_IDLE;
        default: begin
          w_load  = 1'b1;
          w_brake = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
          w_make  = ~w_brake;
          w_nxt   = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= ST_IDLE;
      r_keycode   <= '0;
      r_make      <= 1'b0;
      r_brake     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_make      <= w_make;
      r_brake     <= w_brake;
      r_frame_err <= w_frame_err;
      if (w_load) r_keycode <= KEYCODE_WIDTH'({w_ext, w_byte});
    end
  end

  assign keyCode  = r_keycode;
  assign make     = r_make;
  assign brake    = r_brake;
  assign frameErr = r_frame_err;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder: drives PS/2 frames, expects make/brake/frameErr events in order.
module tb_ps2_scan_decoder;

  localparam int TO = 200;
  localparam int HP = 6;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic [8:0] keyCode;
  logic       make, brake, frameErr;

  always #5 clk = ~clk;

  ps2_scan_decoder #(.KEYCODE_WIDTH(9), .TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .resetN  (resetN),
    .PS2_CLK (ps2c),
    .PS2_DAT (ps2d),
    .keyCode (keyCode),
    .make    (make),
    .brake   (brake),
    .frameErr(frameErr)
  );

  typedef struct {
    logic       mk;
    logic       bk;
    logic       er;
    logic [8:0] kc;
  } ev_t;

  ev_t        q[$];
  logic [8:0] exp_kc = 9'h000;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic mk, input logic bk, input logic er, input logic [8:0] kc);
    ev_t e;
    if (mk || bk) exp_kc = kc;
    e.mk = mk; e.bk = bk; e.er = er; e.kc = exp_kc;
    q.push_back(e);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2d = f[i];
      repeat (HP/2) @(posedge clk);
      ps2c = 1'b0;
      repeat (HP) @(posedge clk);
      ps2c = 1'b1;
      repeat (HP/2) @(posedge clk);
    end
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] d, input logic badp, input logic bads);
    logic p;
    p = (~^d) ^ badp;
    return {~bads, p, d, 1'b0};
  endfunction

  task automatic frame(input logic [7:0] d, input logic badp, input logic bads);
    send_bits(mkframe(d, badp, bads), 11);
    repeat (10) @(posedge clk);
  endtask

  // Every output pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (resetN) begin
      if (make && brake) chk("make_brake_excl", 16'(make & brake), 16'h0);
      if (make || brake || frameErr) begin
        if (q.size() == 0) begin
          chk("unexpected_evt", 16'({make, brake, frameErr}), 16'h0);
        end else begin
          ev_t e;
          e = q.pop_front();
          chk("make", 16'(make), 16'(e.mk));
          chk("brake", 16'(brake), 16'(e.bk));
          chk("frameErr", 16'(frameErr), 16'(e.er));
          chk("keyCode", 16'(keyCode), 16'(e.kc));
        end
      end
    end
  end

  task automatic chk_reset_outs(input string tag);
    @(negedge clk);
    chk({tag, "_keyCode"}, 16'(keyCode), 16'h0);
    chk({tag, "_make"}, 16'(make), 16'h0);
    chk({tag, "_brake"}, 16'(brake), 16'h0);
    chk({tag, "_frameErr"}, 16'(frameErr), 16'h0);
  endtask

  initial begin
    resetN = 1'b0;
    repeat (3) @(posedge clk);
    chk_reset_outs("rst");
    @(posedge clk);
    resetN = 1'b1;
    repeat (5) @(posedge clk);

    // press W
    push(1, 0, 0, 9'h01D); frame(8'h1D, 0, 0);
    // release W
    frame(8'hF0, 0, 0);
    push(0, 1, 0, 9'h01D); frame(8'h1D, 0, 0);
    // release left arrow
    frame(8'hE0, 0, 0); frame(8'hF0, 0, 0);
    push(0, 1, 0, 9'h16B); frame(8'h6B, 0, 0);
    // press extended key
    frame(8'hE0, 0, 0);
    push(1, 0, 0, 9'h174); frame(8'h74, 0, 0);
    // wrong parity
`ifdef PS2_PARITY_CHECK_EN
    push(0, 0, 1, exp_kc); frame(8'h29, 1, 0);
`else
    push(1, 0, 0, 9'h029); frame(8'h29, 1, 0);
`endif
    // bad stop bit always discards
    push(0, 0, 1, exp_kc); frame(8'h33, 0, 1);
    // auto-repeat
    for (int i = 0; i < 3; i++) begin
      push(1, 0, 0, 9'h01C); frame(8'h1C, 0, 0);
    end
    // E1 silently dropped
    frame(8'hE1, 0, 0);
    push(1, 0, 0, 9'h023); frame(8'h23, 0, 0);
    // repeated E0 is ignored, extension kept
    frame(8'hE0, 0, 0); frame(8'hE0, 0, 0);
    push(1, 0, 0, 9'h16B); frame(8'h6B, 0, 0);
    // start bit sampled as 1 is not a frame start
    send_bits(11'h001, 1);
    push(1, 0, 0, 9'h029); frame(8'h29, 0, 0);
    // PS2_CLK stalls mid-frame
    push(0, 0, 1, exp_kc);
    send_bits(mkframe(8'h29, 0, 0), 5);
    repeat (TO + 20) @(posedge clk);
    push(1, 0, 0, 9'h029); frame(8'h29, 0, 0);
    // reset after E0 and mid-frame
    frame(8'hE0, 0, 0);
    send_bits(mkframe(8'h74, 0, 0), 6);
    resetN = 1'b0;
    repeat (2) @(posedge clk);
    chk_reset_outs("midrst");
    exp_kc = 9'h000;
    @(posedge clk);
    resetN = 1'b1;
    repeat (5) @(posedge clk);
    push(1, 0, 0, 9'h074); frame(8'h74, 0, 0);

    repeat (20) @(posedge clk);
    chk("queue_empty", 16'(q.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
